// File: rtl/mem_resp_queue.sv
// In-order tracker for outstanding data-sram requests: pairs each response with its issuing op,
// formats load data and presents completed entries to WB. Define MEM_RESP_LWLR_EN for LWL/LWR merges.
module mem_resp_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_exc,
  input  logic             issue_load,
  input  logic [2:0]       issue_op,
  input  logic [1:0]       issue_lo,
  input  logic [4:0]       issue_dest,
  input  logic [31:0]      issue_pc,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_we,
  output logic [4:0]       out_dest,
  output logic [31:0]      out_pc,
  output logic             out_exc,
  output logic [PTR_W:0]   count,
  output logic [PTR_W:0]   drop_pend
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2
  } entry_state_e;

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_C   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  entry_state_e     state_q  [DEPTH];
  entry_state_e     state_d  [DEPTH];
  logic [31:0]      result_q [DEPTH];
  logic [31:0]      result_d [DEPTH];
  logic [3:0]       we_q     [DEPTH];
  logic [3:0]       we_d     [DEPTH];
  logic [4:0]       dest_q   [DEPTH];
  logic [4:0]       dest_d   [DEPTH];
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      pc_d     [DEPTH];
  logic             exc_q    [DEPTH];
  logic             exc_d    [DEPTH];
  logic             load_q   [DEPTH];
  logic             load_d   [DEPTH];
  logic [2:0]       op_q     [DEPTH];
  logic [2:0]       op_d     [DEPTH];
  logic [1:0]       lo_q     [DEPTH];
  logic [1:0]       lo_d     [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] resp_q, resp_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W:0]   drop_q, drop_d;
  logic             err_q, err_d;

  logic             do_issue;
  logic             do_retire;
  logic [35:0]      fmt;
  logic [PTR_W:0]   wait_cnt;
  logic [PTR_W-1:0] scan_idx;
  logic             found;

  // Returns {we, result} for one response given the op captured at issue time.
  function automatic logic [35:0] format_load(input logic        is_load,
                                              input logic [2:0]  op,
                                              input logic [1:0]  lo,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    logic [3:0]  we;
    b   = 8'(d >> {lo, 3'b000});
    h   = lo[1] ? d[31:16] : d[15:0];
    res = d;
    we  = 4'hF;
    if (!is_load) begin
      res = '0;
      we  = 4'h0;
    end else begin
      case (op)
        3'd1:    res = {{24{b[7]}}, b};
        3'd2:    res = {24'd0, b};
        3'd3:    res = {{16{h[15]}}, h};
        3'd4:    res = {16'd0, h};
`ifdef MEM_RESP_LWLR_EN
        3'd5: begin
          res = d << {~lo, 3'b000};
          we  = 4'hF << ~lo;
        end
        3'd6: begin
          res = d >> {lo, 3'b000};
          we  = 4'hF >> lo;
        end
`endif
        default: res = d;
      endcase
    end
    return {we, res};
  endfunction

  assign issue_ready = (count_q < DEPTH_C) && !flush;
  assign out_valid   = (state_q[head_q] == ST_DONE) && !flush;
  assign out_result  = result_q[head_q];
  assign out_we      = we_q[head_q];
  assign out_dest    = dest_q[head_q];
  assign out_pc      = pc_q[head_q];
  assign out_exc     = exc_q[head_q];
  assign count       = count_q;
  assign drop_pend   = drop_q;
  assign do_issue    = issue_valid && issue_ready;
  assign do_retire   = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    we_d     = we_q;
    dest_d   = dest_q;
    pc_d     = pc_q;
    exc_d    = exc_q;
    load_d   = load_q;
    op_d     = op_q;
    lo_d     = lo_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    drop_d   = drop_q;
    err_d    = err_q;
    wait_cnt = '0;
    scan_idx = '0;
    found    = 1'b0;
    fmt      = format_load(load_q[resp_q], op_q[resp_q], lo_q[resp_q], rdata);

    // Responses owed to killed entries are swallowed before any live entry can complete.
    if (data_ok) begin
      if (drop_q != '0) begin
        drop_d = drop_q - ONE_C;
      end else if (state_q[resp_q] == ST_WAIT) begin
        state_d[resp_q]  = ST_DONE;
        result_d[resp_q] = fmt[31:0];
        we_d[resp_q]     = fmt[35:32];
      end else begin
        err_d = 1'b1;
      end
    end

    if (do_retire) begin
      state_d[head_q] = ST_EMPTY;
      head_d          = head_q + PTR_ONE;
      count_d         = count_d - ONE_C;
    end

    if (do_issue) begin
      state_d[tail_q]  = issue_exc ? ST_DONE : ST_WAIT;
      result_d[tail_q] = '0;
      we_d[tail_q]     = 4'h0;
      dest_d[tail_q]   = issue_dest;
      pc_d[tail_q]     = issue_pc;
      exc_d[tail_q]    = issue_exc;
      load_d[tail_q]   = issue_load;
      op_d[tail_q]     = issue_op;
      lo_d[tail_q]     = issue_lo;
      tail_d           = tail_q + PTR_ONE;
      count_d          = count_d + ONE_C;
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (state_d[i] == ST_WAIT) wait_cnt = wait_cnt + ONE_C;
    end

    // Counting WAITs after this cycle's completion makes a coincident response land before the kill.
    if (flush) begin
      drop_d = drop_d + wait_cnt;
      for (int i = 0; i < DEPTH; i++) state_d[i] = ST_EMPTY;
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end

    resp_d = tail_d;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = resp_q + PTR_W'(i);
      if (!found && state_d[scan_idx] == ST_WAIT) begin
        resp_d = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      resp_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i]  <= ST_EMPTY;
        result_q[i] <= '0;
        we_q[i]     <= '0;
        dest_q[i]   <= '0;
        pc_q[i]     <= '0;
        exc_q[i]    <= 1'b0;
        load_q[i]   <= 1'b0;
        op_q[i]     <= '0;
        lo_q[i]     <= '0;
      end
    end else begin
      head_q  <= head_d;
      resp_q  <= resp_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i]  <= state_d[i];
        result_q[i] <= result_d[i];
        we_q[i]     <= we_d[i];
        dest_q[i]   <= dest_d[i];
        pc_q[i]     <= pc_d[i];
        exc_q[i]    <= exc_d[i];
        load_q[i]   <= load_d[i];
        op_q[i]     <= op_d[i];
        lo_q[i]     <= lo_d[i];
      end
    end
  end

  // A response with nothing to complete means the memory side and this queue have lost sync.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset) !err_q);

endmodule

// File: tb/tb_mem_resp_queue.sv
// Directed, table-driven bench for mem_resp_queue: one record per clock of inputs and expected
// outputs, plus hand-written reset sequences. Expectations follow MEM_RESP_LWLR_EN if defined.
module tb_mem_resp_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_exc;
  logic        issue_load;
  logic [2:0]  issue_op;
  logic [1:0]  issue_lo;
  logic [4:0]  issue_dest;
  logic [31:0] issue_pc;
  logic        data_ok;
  logic [31:0] rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_we;
  logic [4:0]  out_dest;
  logic [31:0] out_pc;
  logic        out_exc;
  logic [2:0]  count;
  logic [2:0]  drop_pend;

  // Inputs for one cycle followed by the outputs expected before that cycle's clock edge.
  typedef struct {
    bit [31:0] fl, iv, ex, ld, op, lo, dst, dok, rd, ordy;
    bit [31:0] ir, ov, cnt, drp, res, we, edst, eexc;
  } vec_t;

  vec_t      vecs[$];
  int        n_applied;
  int        n_miss;
  bit [31:0] lwl_res, lwl_we, lwr_res, lwr_we;

  mem_resp_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_exc   (issue_exc),
    .issue_load  (issue_load),
    .issue_op    (issue_op),
    .issue_lo    (issue_lo),
    .issue_dest  (issue_dest),
    .issue_pc    (issue_pc),
    .data_ok     (data_ok),
    .rdata       (rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_we      (out_we),
    .out_dest    (out_dest),
    .out_pc      (out_pc),
    .out_exc     (out_exc),
    .count       (count),
    .drop_pend   (drop_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit [31:0] pcOf(input bit [31:0] dst);
    return 32'hBFC0_0000 + (dst << 2);
  endfunction

  task automatic addVec(input vec_t v);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    flush       = v.fl[0];
    issue_valid = v.iv[0];
    issue_exc   = v.ex[0];
    issue_load  = v.ld[0];
    issue_op    = v.op[2:0];
    issue_lo    = v.lo[1:0];
    issue_dest  = v.dst[4:0];
    issue_pc    = pcOf(v.dst);
    data_ok     = v.dok[0];
    rdata       = v.rd;
    out_ready   = v.ordy[0];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input bit [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    vec_t v;
    v = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
    applyStimulus(v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_applied = 0;
    n_miss    = 0;
`ifdef MEM_RESP_LWLR_EN
    lwl_res = 32'hCCDD_0000; lwl_we = 32'hC;
    lwr_res = 32'h0000_AABB; lwr_we = 32'h3;
`else
    lwl_res = 32'hAABB_CCDD; lwl_we = 32'hF;
    lwr_res = 32'hAABB_CCDD; lwr_we = 32'hF;
`endif

    // fl iv ex ld op lo dst dok rdata ordy | ir ov cnt drp result we dest exc
    // Load formatting, one at a time; retire overlaps the next issue.
    addVec('{0,1,0,1,1,3,5,  0,0,0,            1,0,0,0, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  1,'h80FF1234,0,   1,0,1,0, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  0,0,1,            1,1,1,0, 'hFFFFFF80,'hF,5,0});
    addVec('{0,1,0,1,2,3,6,  0,0,0,            1,0,0,0, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  1,'h80FF1234,0,   1,0,1,0, 0,0,0,0});
    addVec('{0,1,0,1,3,2,7,  0,0,1,            1,1,1,0, 'h00000080,'hF,6,0});
    addVec('{0,0,0,0,0,0,0,  1,'h80017FFF,0,   1,0,1,0, 0,0,0,0});
    addVec('{0,1,0,1,4,0,8,  0,0,1,            1,1,1,0, 'hFFFF8001,'hF,7,0});
    addVec('{0,0,0,0,0,0,0,  1,'h1234ABCD,0,   1,0,1,0, 0,0,0,0});
    addVec('{0,1,0,0,0,0,9,  0,0,1,            1,1,1,0, 'h0000ABCD,'hF,8,0});
    addVec('{0,0,0,0,0,0,0,  1,'hDEADBEEF,0,   1,0,1,0, 0,0,0,0});
    addVec('{0,1,0,1,5,1,10, 0,0,1,            1,1,1,0, 0,0,9,0});
    addVec('{0,0,0,0,0,0,0,  1,'hAABBCCDD,0,   1,0,1,0, 0,0,0,0});
    addVec('{0,1,0,1,7,0,11, 0,0,1,            1,1,1,0, lwl_res,lwl_we,10,0});
    addVec('{0,0,0,0,0,0,0,  1,'h13579BDF,0,   1,0,1,0, 0,0,0,0});
    addVec('{0,1,0,1,6,2,12, 0,0,1,            1,1,1,0, 'h13579BDF,'hF,11,0});
    addVec('{0,0,0,0,0,0,0,  1,'hAABBCCDD,0,   1,0,1,0, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  0,0,1,            1,1,1,0, lwr_res,lwr_we,12,0});
    addVec('{0,0,0,0,0,0,0,  0,0,0,            1,0,0,0, 0,0,0,0});
    // Fill to DEPTH, refused fifth issue, WB stalls three cycles then drains in order.
    addVec('{0,1,0,1,0,0,1,  0,0,0,            1,0,0,0, 0,0,0,0});
    addVec('{0,1,0,1,0,0,2,  0,0,0,            1,0,1,0, 0,0,0,0});
    addVec('{0,1,0,1,0,0,3,  0,0,0,            1,0,2,0, 0,0,0,0});
    addVec('{0,1,0,1,0,0,4,  0,0,0,            1,0,3,0, 0,0,0,0});
    addVec('{0,1,0,1,0,0,5,  1,'hA,0,          0,0,4,0, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  1,'hB,0,          0,1,4,0, 'hA,'hF,1,0});
    addVec('{0,0,0,0,0,0,0,  1,'hC,0,          0,1,4,0, 'hA,'hF,1,0});
    addVec('{0,0,0,0,0,0,0,  1,'hD,0,          0,1,4,0, 'hA,'hF,1,0});
    addVec('{0,0,0,0,0,0,0,  0,0,1,            0,1,4,0, 'hA,'hF,1,0});
    addVec('{0,0,0,0,0,0,0,  0,0,1,            1,1,3,0, 'hB,'hF,2,0});
    addVec('{0,0,0,0,0,0,0,  0,0,1,            1,1,2,0, 'hC,'hF,3,0});
    addVec('{0,0,0,0,0,0,0,  0,0,1,            1,1,1,0, 'hD,'hF,4,0});
    addVec('{0,0,0,0,0,0,0,  0,0,0,            1,0,0,0, 0,0,0,0});
    // Pre-faulted op between two loads: done at issue, takes no response, retires in order.
    addVec('{0,1,0,1,0,0,20, 0,0,0,            1,0,0,0, 0,0,0,0});
    addVec('{0,1,1,1,1,0,21, 0,0,0,            1,0,1,0, 0,0,0,0});
    addVec('{0,1,0,1,0,0,22, 0,0,0,            1,0,2,0, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  1,'h11111111,0,   1,0,3,0, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  1,'h22222222,0,   1,1,3,0, 'h11111111,'hF,20,0});
    addVec('{0,0,0,0,0,0,0,  0,0,1,            1,1,3,0, 'h11111111,'hF,20,0});
    addVec('{0,0,0,0,0,0,0,  0,0,1,            1,1,2,0, 0,0,21,1});
    addVec('{0,0,0,0,0,0,0,  0,0,1,            1,1,1,0, 'h22222222,'hF,22,0});
    addVec('{0,0,0,0,0,0,0,  0,0,0,            1,0,0,0, 0,0,0,0});
    // Flush with three WAIT and one DONE, then a new load waits behind three drops.
    addVec('{0,1,0,1,0,0,1,  0,0,0,            1,0,0,0, 0,0,0,0});
    addVec('{0,1,0,1,0,0,2,  0,0,0,            1,0,1,0, 0,0,0,0});
    addVec('{0,1,0,1,0,0,3,  0,0,0,            1,0,2,0, 0,0,0,0});
    addVec('{0,1,0,1,0,0,4,  1,'hAAAA0001,0,   1,0,3,0, 0,0,0,0});
    addVec('{1,0,0,0,0,0,0,  0,0,1,            0,0,4,0, 0,0,0,0});
    addVec('{0,1,0,1,0,0,9,  0,0,0,            1,0,0,3, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  1,'hD1,0,         1,0,1,3, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  1,'hD2,0,         1,0,1,2, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  1,'hD3,0,         1,0,1,1, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  1,'h00000C0C,0,   1,0,1,0, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  0,0,1,            1,1,1,0, 'h00000C0C,'hF,9,0});
    addVec('{0,0,0,0,0,0,0,  0,0,0,            1,0,0,0, 0,0,0,0});
    // Flush coinciding with a response, two WAIT entries: only one drop remains.
    addVec('{0,1,0,1,0,0,1,  0,0,0,            1,0,0,0, 0,0,0,0});
    addVec('{0,1,0,1,0,0,2,  0,0,0,            1,0,1,0, 0,0,0,0});
    addVec('{1,0,0,0,0,0,0,  1,'h77,0,         0,0,2,0, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  1,'h88,0,         1,0,0,1, 0,0,0,0});
    addVec('{0,0,0,0,0,0,0,  0,0,0,            1,0,0,0, 0,0,0,0});

    // Reset state.
    idleInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset issue_ready", 32'(issue_ready), 1);
    checkOutput("reset out_valid",   32'(out_valid),   0);
    checkOutput("reset count",       32'(count),       0);
    checkOutput("reset drop_pend",   32'(drop_pend),   0);
    checkOutput("reset out_result",  out_result,       0);
    checkOutput("reset out_we",      32'(out_we),      0);
    checkOutput("reset out_dest",    32'(out_dest),    0);
    checkOutput("reset out_pc",      out_pc,           0);
    checkOutput("reset out_exc",     32'(out_exc),     0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d issue_ready", i), 32'(issue_ready), vecs[i].ir);
      checkOutput($sformatf("v%0d out_valid", i),   32'(out_valid),   vecs[i].ov);
      checkOutput($sformatf("v%0d count", i),       32'(count),       vecs[i].cnt);
      checkOutput($sformatf("v%0d drop_pend", i),   32'(drop_pend),   vecs[i].drp);
      if (vecs[i].ov != 0) begin
        checkOutput($sformatf("v%0d out_result", i), out_result,       vecs[i].res);
        checkOutput($sformatf("v%0d out_we", i),     32'(out_we),      vecs[i].we);
        checkOutput($sformatf("v%0d out_dest", i),   32'(out_dest),    vecs[i].edst);
        checkOutput($sformatf("v%0d out_pc", i),     out_pc,           pcOf(vecs[i].edst));
        checkOutput($sformatf("v%0d out_exc", i),    32'(out_exc),     vecs[i].eexc);
      end
    end

    // Reset wins over a coincident issue, response and retire while an entry is held.
    @(posedge clk);
    #1 begin
      idleInputs();
      issue_valid = 1'b1; issue_load = 1'b1; issue_dest = 5'd3; issue_pc = pcOf(3);
    end
    @(posedge clk);
    #1 begin
      idleInputs();
      data_ok = 1'b1; rdata = 32'h0000_0055;
    end
    @(posedge clk);
    #1 idleInputs();
    @(negedge clk);
    checkOutput("pre-reset out_valid",  32'(out_valid), 1);
    checkOutput("pre-reset out_result", out_result,     32'h55);
    @(posedge clk);
    #1 begin
      reset = 1'b1; out_ready = 1'b1; data_ok = 1'b1; rdata = 32'h0000_0099;
      issue_valid = 1'b1; issue_load = 1'b1; issue_dest = 5'd7; issue_pc = pcOf(7);
    end
    @(posedge clk);
    #1 begin
      reset = 1'b0;
      idleInputs();
    end
    @(negedge clk);
    checkOutput("rst-prio count",      32'(count),      0);
    checkOutput("rst-prio out_valid",  32'(out_valid),  0);
    checkOutput("rst-prio drop_pend",  32'(drop_pend),  0);
    checkOutput("rst-prio out_result", out_result,      0);
    checkOutput("rst-prio out_dest",   32'(out_dest),   0);
    checkOutput("rst-prio out_pc",     out_pc,          0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_resp_queue.md
MEM_RESP_QUEUE -- requirements
Module: mem_resp_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of outstanding memory requests (power of 2, 2..16).
REQ-002 SHALL have parameter PTR_W, default 2, meaning log2(DEPTH).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  WB exception or eret; kill all held entries
- issue_valid  in  1  EX has issued a data-sram request, or has a pre-faulted op
- issue_ready  out  1  queue accepts the issue
- issue_exc  in  1  op faulted in EX; no memory response will come
- issue_load  in  1  1 = load, 0 = store
- issue_op  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 treated as LW
- issue_lo  in  2  address bits [1:0]
- issue_dest  in  5  destination register
- issue_pc  in  32  instruction PC
- data_ok  in  1  one data-sram response this cycle
- rdata  in  32  response data
- out_valid  out  1  head entry complete
- out_ready  in  1  WB accepts
- out_result  out  32  aligned or extended load data; 0 for stores
- out_we  out  4  byte write strobes for the register file
- out_dest  out  5  destination register
- out_pc  out  32  instruction PC
- out_exc  out  1  entry was issued with issue_exc
- count  out  PTR_W+1  number of live entries
- drop_pend  out  PTR_W+1  responses still owed to killed entries

Function
REQ-004 SHALL hold entries in a circular FIFO with head, resp and tail pointers of PTR_W bits that wrap modulo DEPTH.
REQ-005 SHALL give each entry one of the states EMPTY, WAIT, DONE.
REQ-006 SHALL set issue_ready = (count < DEPTH) && !flush, with no same-cycle bypass from a retiring head.
REQ-007 SHALL write an accepted issue at tail, in state WAIT, or in state DONE with out_exc=1, result 0 and we 0 when issue_exc=1.
REQ-008 SHALL, on data_ok with drop_pend=0, complete the oldest WAIT entry at the resp pointer: store result and we and set the entry to DONE.
REQ-009 SHALL make that entry visible on out_valid the cycle after data_ok (one-cycle latency).
REQ-010 SHALL, on data_ok with drop_pend>0, decrement drop_pend and leave every entry unchanged.
REQ-011 SHALL advance the resp pointer past DONE entries until it reaches a WAIT entry or tail.
REQ-012 SHALL compute load results from rdata and issue_lo (the entry's lo):
- LB/LBU: byte lo, sign- or zero-extended
- LH/LHU: halfword lo[1], sign- or zero-extended
- LW: rdata unchanged
- all three use we = 4'hF
REQ-013 SHALL give stores result 0 and we 4'h0.
REQ-014 SHALL set out_valid when the head entry is DONE, and retire the head on out_valid && out_ready.
REQ-015 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-016 SHALL, on flush:
- add the number of WAIT entries to drop_pend (minus 1 if data_ok also arrives this cycle and drop_pend was 0)
- set all entries to EMPTY
- set head=resp=tail
- suppress out_valid that cycle
REQ-017 SHALL treat a simultaneous flush and data_ok as consuming the response before the kill.
REQ-018 SHALL let issues resume the cycle after a flush while drop_pend>0, with new entries waiting behind the drops.
REQ-019 SHALL ignore data_ok when no WAIT entry exists and drop_pend=0, and hold a sticky internal error bit visible only to assertions.
REQ-020 SHALL update count in the same cycle as a simultaneous issue and retire (net 0).

Reset
REQ-021 SHALL, on reset, clear all entries to EMPTY and zero the pointers, count, drop_pend and out_valid.
REQ-022 SHALL drive out_result, out_we, out_dest, out_pc and out_exc to 0 after reset.
REQ-023 SHALL let reset take priority over flush, issue and data_ok in the same cycle.

Configuration
REQ-024 SHALL use the macro MEM_RESP_LWLR_EN to compile the unaligned-load modes in or out:
- defined: LWL gives result rdata << ((3-lo)*8) with we {1000,1100,1110,1111} for lo 0..3; LWR gives rdata >> (lo*8) with we {1111,0111,0011,0001}
- undefined: ops 5 and 6 decode as LW, result rdata and we 4'hF

Verification
REQ-025 SHALL cover LB at lo=3 with rdata 0x80FF_1234 -> out_result 0xFFFF_FF80 and we F, one cycle after data_ok.
REQ-026 SHALL cover 4 loads issued back to back with DEPTH=4 -> issue_ready=0 at count=4; responses A,B,C,D return in order with out_ready held low 3 cycles and no loss.
REQ-027 SHALL cover flush with 3 WAIT entries and 1 DONE entry -> drop_pend=3, out_valid=0; a new load issued next, then 4 data_ok -> only the 4th completes the new load.
REQ-028 SHALL cover flush and data_ok in the same cycle with 2 WAIT entries -> drop_pend=1.
REQ-029 SHALL cover issue_exc entry between two loads -> retires in order with out_exc=1 and consumes no data_ok.
REQ-030 SHALL cover LWL at lo=1 with rdata 0xAABB_CCDD and MEM_RESP_LWLR_EN defined -> result 0xCCDD_0000, we 1100; with the macro undefined -> result 0xAABB_CCDD, we F.
